// File: rtl/sprite_pkg.sv
// Shared definitions for the sprite blitter: command magic codes, sprite geometry table
// entries, flag bit positions, the descriptor struct and the controller state encoding.
package sprite_pkg;

  localparam int unsigned SprOffsetW = 16;
  localparam int unsigned SprDimW    = 8;

  // Command magic codes
  localparam logic [7:0] MAGIC_DO_RENDER = 8'hFF;
  localparam logic [7:0] MAGIC_SPR_SMALL = 8'h01;
  localparam logic [7:0] MAGIC_SPR_BIG   = 8'h02;
  localparam logic [7:0] MAGIC_SPR_EMPTY = 8'h03;

  // Sprite ROM layout
  localparam logic [SprOffsetW-1:0] SPR_SMALL_OFFSET = 16'd0;
  localparam logic [SprDimW-1:0]    SPR_SMALL_W      = 8'd4;
  localparam logic [SprDimW-1:0]    SPR_SMALL_H      = 8'd2;
  localparam logic [SprOffsetW-1:0] SPR_BIG_OFFSET   = 16'd16;
  localparam logic [SprDimW-1:0]    SPR_BIG_W        = 8'd16;
  localparam logic [SprDimW-1:0]    SPR_BIG_H        = 8'd16;
  // Zero-width sprite slot; must produce no writes
  localparam logic [SprOffsetW-1:0] SPR_EMPTY_OFFSET = 16'd272;
  localparam logic [SprDimW-1:0]    SPR_EMPTY_W      = 8'd0;
  localparam logic [SprDimW-1:0]    SPR_EMPTY_H      = 8'd4;

  // Command flag bit positions
  localparam int unsigned FLAG_HFLIP  = 0;
  localparam int unsigned FLAG_TRANSP = 1;

  typedef struct packed {
    logic [SprOffsetW-1:0] offset;
    logic [SprDimW-1:0]    w;
    logic [SprDimW-1:0]    h;
    logic                  valid;
  } sprite_desc_t;

  typedef enum logic [2:0] {
    StIdle,
    StDesc,
    StDraw,
    StDrain,
    StWaitEof,
    StClear
  } state_e;

endpackage

// File: rtl/sprite_desc_lut.sv
// Sprite descriptor lookup: maps a command magic code to ROM offset, width, height and a
// valid bit. Purely combinational.
//   magic_i : command magic code
//   desc_o  : descriptor; valid=0 for unknown codes
module sprite_desc_lut
  import sprite_pkg::*;
(
  input  logic [7:0]   magic_i,
  output sprite_desc_t desc_o
);

  always_comb begin
    desc_o = '0;
    case (magic_i)
      MAGIC_SPR_SMALL: desc_o = '{offset: SPR_SMALL_OFFSET, w: SPR_SMALL_W,
                                  h: SPR_SMALL_H, valid: 1'b1};
      MAGIC_SPR_BIG:   desc_o = '{offset: SPR_BIG_OFFSET, w: SPR_BIG_W,
                                  h: SPR_BIG_H, valid: 1'b1};
      MAGIC_SPR_EMPTY: desc_o = '{offset: SPR_EMPTY_OFFSET, w: SPR_EMPTY_W,
                                  h: SPR_EMPTY_H, valid: 1'b1};
      default:         desc_o = '0;
    endcase
  end

endmodule

// File: rtl/sprite_blitter.sv
// Sprite blitter and double-buffer controller. Pops draw commands, streams sprite ROM pixels
// into the back buffer at one pixel per cycle with clipping, colour-key transparency and
// horizontal flip; DO_RENDER waits for end of field, swaps buffers and clears the new back.
//   clk50_i/reset_i            : clock, synchronous active-high reset
//   cmd_valid_i/cmd_data_i     : command queue head; cmd_ready_o pops it
//   pix_addr_o/pix_din_i       : sprite ROM port, data one cycle after address
//   fb_we_o/fb_addr_o/fb_din_o : back-buffer write port
//   end_of_field_i             : field pulse; front_sel_o selects the displayed buffer
//   busy_o/frame_cnt_o         : not idle / completed swap count
module sprite_blitter
  import sprite_pkg::*;
#(
  parameter int unsigned         SCREEN_W      = 640,
  parameter int unsigned         SCREEN_H      = 480,
  parameter int unsigned         PIXEL_W       = 24,
  parameter int unsigned         SPR_ADDR_W    = 16,
  parameter logic [PIXEL_W-1:0]  KEY_COLOR     = 24'hFF00FF,
  parameter logic [PIXEL_W-1:0]  CLEAR_COLOR   = '0,
  parameter bit                  CLEAR_ON_SWAP = 1'b1,
  localparam int unsigned        FB_AW         = $clog2(SCREEN_W * SCREEN_H)
) (
  input  logic                  clk50_i,
  input  logic                  reset_i,
  input  logic                  cmd_valid_i,
  input  logic [47:0]           cmd_data_i,
  output logic                  cmd_ready_o,
  output logic [SPR_ADDR_W-1:0] pix_addr_o,
  input  logic [PIXEL_W-1:0]    pix_din_i,
  output logic                  fb_we_o,
  output logic [FB_AW-1:0]      fb_addr_o,
  output logic [PIXEL_W-1:0]    fb_din_o,
  input  logic                  end_of_field_i,
  output logic                  front_sel_o,
  output logic                  busy_o,
  output logic [15:0]           frame_cnt_o
);

  localparam logic [FB_AW-1:0] ClrLast = FB_AW'(SCREEN_W * SCREEN_H - 1);

  state_e                state_q, state_d;
  logic                  render_q, render_d, drain_q, drain_d;
  logic [7:0]            magic_q, magic_d;
  logic [15:0]           x_q, x_d, y_q, y_d;
  logic                  hflip_q, hflip_d, transp_q, transp_d;
  logic [SprDimW-1:0]    w_q, w_d, h_q, h_d, cx_q, cx_d, cy_q, cy_d;
  logic [SPR_ADDR_W-1:0] row_base_q, row_base_d, pix_addr_q, pix_addr_d, row_base_nxt;
  logic [16:0]           col_org_q, col_org_d;
  logic                  s1_valid_q, s1_valid_d;
  logic [16:0]           s1_col_q, s1_col_d, s1_row_q, s1_row_d;
  logic                  fb_we_q, fb_we_d;
  logic [FB_AW-1:0]      fb_addr_q, fb_addr_d, clr_cnt_q, clr_cnt_d;
  logic [PIXEL_W-1:0]    fb_din_q, fb_din_d;
  logic                  front_sel_q, front_sel_d;
  logic [15:0]           frame_cnt_q, frame_cnt_d;
  logic                  in_bounds, keyed;
  sprite_desc_t          desc;
  logic                  unused_flag_bits;

  assign unused_flag_bits = ^cmd_data_i[7:2];

  sprite_desc_lut u_desc_lut (
    .magic_i (magic_q),
    .desc_o  (desc)
  );

  // Stage t+1: destination known from stage-1 registers, ROM data now present.
  // Sign bits are checked first so the unsigned upper-bound compares are safe.
  assign in_bounds = !s1_col_q[16] && !s1_row_q[16] &&
                     (s1_col_q < 17'(SCREEN_W)) && (s1_row_q < 17'(SCREEN_H));
  assign keyed     = transp_q && (pix_din_i == KEY_COLOR);
  assign row_base_nxt = row_base_q + SPR_ADDR_W'(w_q);

  always_comb begin
    state_d     = state_q;
    render_d    = render_q;
    drain_d     = drain_q;
    magic_d     = magic_q;
    x_d         = x_q;
    y_d         = y_q;
    hflip_d     = hflip_q;
    transp_d    = transp_q;
    w_d         = w_q;
    h_d         = h_q;
    cx_d        = cx_q;
    cy_d        = cy_q;
    row_base_d  = row_base_q;
    pix_addr_d  = pix_addr_q;
    col_org_d   = col_org_q;
    s1_valid_d  = 1'b0;
    s1_col_d    = s1_col_q;
    s1_row_d    = s1_row_q;
    fb_we_d     = 1'b0;
    fb_addr_d   = fb_addr_q;
    fb_din_d    = fb_din_q;
    clr_cnt_d   = clr_cnt_q;
    front_sel_d = front_sel_q;
    frame_cnt_d = frame_cnt_q;
    cmd_ready_o = 1'b0;

    if (s1_valid_q && in_bounds && !keyed) begin
      fb_we_d   = 1'b1;
      fb_addr_d = FB_AW'(32'(s1_row_q) * SCREEN_W + 32'(s1_col_q));
      fb_din_d  = pix_din_i;
    end

    unique case (state_q)
      StIdle: begin
        cmd_ready_o = cmd_valid_i && !reset_i;
        if (cmd_valid_i) begin
          magic_d  = cmd_data_i[47:40];
          x_d      = cmd_data_i[39:24];
          y_d      = cmd_data_i[23:8];
          hflip_d  = cmd_data_i[FLAG_HFLIP];
          transp_d = cmd_data_i[FLAG_TRANSP];
          if (cmd_data_i[47:40] == MAGIC_DO_RENDER) begin
            render_d = 1'b1;
            drain_d  = 1'b0;
            state_d  = StDrain;
          end else begin
            render_d = 1'b0;
            state_d  = StDesc;
          end
        end
      end
      StDesc: begin
        if (!desc.valid || desc.w == '0 || desc.h == '0) begin
          state_d = StIdle;
        end else begin
          w_d        = desc.w;
          h_d        = desc.h;
          cx_d       = '0;
          cy_d       = '0;
          row_base_d = SPR_ADDR_W'(desc.offset);
          pix_addr_d = SPR_ADDR_W'(desc.offset) +
                       (hflip_q ? SPR_ADDR_W'(desc.w - 8'd1) : '0);
          col_org_d  = {x_q[15], x_q} - 17'(desc.w >> 1);
          state_d    = StDraw;
        end
      end
      StDraw: begin
        s1_valid_d = 1'b1;
        s1_col_d   = col_org_q + 17'(cx_q);
        s1_row_d   = {y_q[15], y_q} + 17'(cy_q);
        if (cx_q == w_q - 8'd1) begin
          if (cy_q == h_q - 8'd1) begin
            drain_d = 1'b0;
            state_d = StDrain;
          end else begin
            cx_d       = '0;
            cy_d       = cy_q + 8'd1;
            row_base_d = row_base_nxt;
            pix_addr_d = row_base_nxt + (hflip_q ? SPR_ADDR_W'(w_q - 8'd1) : '0);
          end
        end else begin
          cx_d       = cx_q + 8'd1;
          pix_addr_d = hflip_q ? pix_addr_q - SPR_ADDR_W'(1) : pix_addr_q + SPR_ADDR_W'(1);
        end
      end
      StDrain: begin
        drain_d = 1'b1;
        if (drain_q) state_d = render_q ? StWaitEof : StIdle;
      end
      StWaitEof: begin
        if (end_of_field_i) begin
          front_sel_d = ~front_sel_q;
          frame_cnt_d = frame_cnt_q + 16'd1;
          clr_cnt_d   = '0;
          state_d     = CLEAR_ON_SWAP ? StClear : StIdle;
        end
      end
      StClear: begin
        fb_we_d   = 1'b1;
        fb_addr_d = clr_cnt_q;
        fb_din_d  = CLEAR_COLOR;
        if (clr_cnt_q == ClrLast) state_d = StIdle;
        else clr_cnt_d = clr_cnt_q + FB_AW'(1);
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk50_i) begin
    if (reset_i) begin
      state_q     <= StIdle;
      render_q    <= 1'b0;
      drain_q     <= 1'b0;
      magic_q     <= '0;
      x_q         <= '0;
      y_q         <= '0;
      hflip_q     <= 1'b0;
      transp_q    <= 1'b0;
      w_q         <= '0;
      h_q         <= '0;
      cx_q        <= '0;
      cy_q        <= '0;
      row_base_q  <= '0;
      pix_addr_q  <= '0;
      col_org_q   <= '0;
      s1_valid_q  <= 1'b0;
      s1_col_q    <= '0;
      s1_row_q    <= '0;
      fb_we_q     <= 1'b0;
      fb_addr_q   <= '0;
      fb_din_q    <= '0;
      clr_cnt_q   <= '0;
      front_sel_q <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      render_q    <= render_d;
      drain_q     <= drain_d;
      magic_q     <= magic_d;
      x_q         <= x_d;
      y_q         <= y_d;
      hflip_q     <= hflip_d;
      transp_q    <= transp_d;
      w_q         <= w_d;
      h_q         <= h_d;
      cx_q        <= cx_d;
      cy_q        <= cy_d;
      row_base_q  <= row_base_d;
      pix_addr_q  <= pix_addr_d;
      col_org_q   <= col_org_d;
      s1_valid_q  <= s1_valid_d;
      s1_col_q    <= s1_col_d;
      s1_row_q    <= s1_row_d;
      fb_we_q     <= fb_we_d;
      fb_addr_q   <= fb_addr_d;
      fb_din_q    <= fb_din_d;
      clr_cnt_q   <= clr_cnt_d;
      front_sel_q <= front_sel_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign pix_addr_o  = pix_addr_q;
  assign fb_we_o     = fb_we_q;
  assign fb_addr_o   = fb_addr_q;
  assign fb_din_o    = fb_din_q;
  assign front_sel_o = front_sel_q;
  assign frame_cnt_o = frame_cnt_q;
  assign busy_o      = (state_q != StIdle);

endmodule

// File: tb/tb_sprite_blitter.sv
// Self-checking bench for sprite_blitter. Screen height is reduced so a full buffer clear
// stays short; width is kept at 640 so destination addresses match the 640-wide layout.
module tb_sprite_blitter;
  import sprite_pkg::*;

  localparam int unsigned SW    = 640;
  localparam int unsigned SH    = 48;
  localparam int unsigned FB_AW = $clog2(SW * SH);
  localparam logic [23:0] KEY   = 24'hFF00FF;

  logic              clk = 1'b0;
  logic              reset;
  logic              cmd_valid;
  logic [47:0]       cmd_data;
  logic              cmd_ready;
  logic [15:0]       pix_addr;
  logic [23:0]       pix_din;
  logic              fb_we;
  logic [FB_AW-1:0]  fb_addr;
  logic [23:0]       fb_din;
  logic              end_of_field;
  logic              front_sel;
  logic              busy;
  logic [15:0]       frame_cnt;

  typedef struct packed {
    logic [FB_AW-1:0] addr;
    logic [23:0]      data;
  } wr_t;

  wr_t         exp_q[$];
  wr_t         act_q[$];
  logic [23:0] rom [65536];
  int          checks = 0;
  int          failures = 0;

  sprite_blitter #(
    .SCREEN_W      (SW),
    .SCREEN_H      (SH),
    .PIXEL_W       (24),
    .SPR_ADDR_W    (16),
    .KEY_COLOR     (KEY),
    .CLEAR_COLOR   (24'h000000),
    .CLEAR_ON_SWAP (1'b1)
  ) dut (
    .clk50_i        (clk),
    .reset_i        (reset),
    .cmd_valid_i    (cmd_valid),
    .cmd_data_i     (cmd_data),
    .cmd_ready_o    (cmd_ready),
    .pix_addr_o     (pix_addr),
    .pix_din_i      (pix_din),
    .fb_we_o        (fb_we),
    .fb_addr_o      (fb_addr),
    .fb_din_o       (fb_din),
    .end_of_field_i (end_of_field),
    .front_sel_o    (front_sel),
    .busy_o         (busy),
    .frame_cnt_o    (frame_cnt)
  );

  always #5 clk = ~clk;

  // Synchronous sprite ROM: data valid one cycle after the address
  always @(posedge clk) pix_din <= rom[pix_addr];

  // Write capture, sampled mid-cycle
  always @(negedge clk) begin
    if (!reset && fb_we) act_q.push_back('{addr: fb_addr, data: fb_din});
  end

  // Reference model: push the writes a sprite command should produce
  task automatic model_sprite(input int off, input int w, input int h, input int x,
                              input int y, input logic [7:0] fl);
    for (int r = 0; r < h; r++) begin
      for (int c = 0; c < w; c++) begin
        int col, row, src;
        logic [23:0] px;
        col = x - w / 2 + c;
        row = y + r;
        src = off + r * w + (fl[0] ? w - 1 - c : c);
        px  = rom[src];
        if (col >= 0 && col < int'(SW) && row >= 0 && row < int'(SH) && !(fl[1] && px == KEY))
          exp_q.push_back('{addr: FB_AW'(row * int'(SW) + col), data: px});
      end
    end
  endtask

  // Issue one command and wait for idle; n counts cycles from transfer, first_we the first write
  task automatic send_cmd(input logic [7:0] m, input int x, input int y, input logic [7:0] fl,
                          input int limit, output int n, output int first_we);
    cmd_data  = {m, 16'(x), 16'(y), fl};
    cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    n = 1;
    first_we = 0;
    while (busy && n < limit) begin
      @(posedge clk); #1;
      n++;
      if (fb_we && first_we == 0) first_we = n;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; cmd_valid = 1'b1; cmd_data = '0; end_of_field = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (cmd_ready !== 1'b0) begin failures++; $display("FAIL reset_cmd_ready got=%b want=0", cmd_ready); end
    checks++; if (pix_addr !== 16'd0) begin failures++; $display("FAIL reset_pix_addr got=%0d want=0", pix_addr); end
    checks++; if (fb_we !== 1'b0) begin failures++; $display("FAIL reset_fb_we got=%b want=0", fb_we); end
    checks++; if (fb_addr !== '0 || fb_din !== '0) begin failures++; $display("FAIL reset_fb_bus got=%0d/%h want=0/0", fb_addr, fb_din); end
    checks++; if (front_sel !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL reset_sel_busy got=%b/%b want=0/0", front_sel, busy); end
    checks++; if (frame_cnt !== 16'd0) begin failures++; $display("FAIL reset_frame_cnt got=%0d want=0", frame_cnt); end
    cmd_valid = 1'b0;
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    int n, fw;
    exp_q.delete(); act_q.delete();
    model_sprite(0, 4, 2, 10, 5, 8'h00);
    send_cmd(MAGIC_SPR_SMALL, 10, 5, 8'h00, 100, n, fw);
    checks++; if (n !== 12) begin failures++; $display("FAIL basic_cycles got=%0d want=12", n); end
    checks++; if (fw !== 4) begin failures++; $display("FAIL basic_first_we got=%0d want=4", fw); end
    checks++; if (act_q.size() !== 8) begin failures++; $display("FAIL basic_count got=%0d want=8", act_q.size()); end
    checks++;
    if (act_q.size() < 1 || act_q[0] !== '{addr: FB_AW'(3208), data: rom[0]}) begin
      failures++; $display("FAIL basic_first_addr got=%0d want=3208", act_q.size() > 0 ? int'(act_q[0].addr) : -1);
    end
    while (exp_q.size() > 0 && act_q.size() > 0) begin
      wr_t e, a;
      e = exp_q.pop_front(); a = act_q.pop_front();
      checks++; if (a !== e) begin failures++; $display("FAIL basic_write got=%0d:%h want=%0d:%h", a.addr, a.data, e.addr, e.data); end
    end
  endtask

  task automatic test_hflip();
    int n, fw;
    exp_q.delete(); act_q.delete();
    model_sprite(0, 4, 2, 10, 5, 8'h01);
    send_cmd(MAGIC_SPR_SMALL, 10, 5, 8'h01, 100, n, fw);
    checks++; if (act_q.size() !== exp_q.size()) begin failures++; $display("FAIL hflip_count got=%0d want=%0d", act_q.size(), exp_q.size()); end
    checks++; if (act_q.size() < 1 || act_q[0].data !== rom[3]) begin failures++; $display("FAIL hflip_first_pixel got=%h want=%h", act_q.size() > 0 ? act_q[0].data : 24'hx, rom[3]); end
    while (exp_q.size() > 0 && act_q.size() > 0) begin
      wr_t e, a;
      e = exp_q.pop_front(); a = act_q.pop_front();
      checks++; if (a !== e) begin failures++; $display("FAIL hflip_write got=%0d:%h want=%0d:%h", a.addr, a.data, e.addr, e.data); end
    end
  endtask

  task automatic test_transp();
    int n, fw;
    bit hit;
    exp_q.delete(); act_q.delete();
    model_sprite(0, 4, 2, 10, 5, 8'h02);
    send_cmd(MAGIC_SPR_SMALL, 10, 5, 8'h02, 100, n, fw);
    hit = 1'b0;
    foreach (act_q[i]) if (act_q[i].addr == FB_AW'(3210)) hit = 1'b1;
    checks++; if (hit !== 1'b0) begin failures++; $display("FAIL transp_key_written got=1 want=0"); end
    checks++; if (act_q.size() !== 7) begin failures++; $display("FAIL transp_count got=%0d want=7", act_q.size()); end
    checks++; if (n !== 12) begin failures++; $display("FAIL transp_cycles got=%0d want=12", n); end
    while (exp_q.size() > 0 && act_q.size() > 0) begin
      wr_t e, a;
      e = exp_q.pop_front(); a = act_q.pop_front();
      checks++; if (a !== e) begin failures++; $display("FAIL transp_write got=%0d:%h want=%0d:%h", a.addr, a.data, e.addr, e.data); end
    end
  endtask

  task automatic test_clip();
    int n, fw;
    int xs[3] = '{1, 10, 639};
    int ys[3] = '{5, 47, 20};
    int want[3] = '{6, 4, 6};
    for (int k = 0; k < 3; k++) begin
      exp_q.delete(); act_q.delete();
      model_sprite(0, 4, 2, xs[k], ys[k], 8'h00);
      send_cmd(MAGIC_SPR_SMALL, xs[k], ys[k], 8'h00, 100, n, fw);
      checks++; if (act_q.size() !== want[k]) begin failures++; $display("FAIL clip_count case=%0d got=%0d want=%0d", k, act_q.size(), want[k]); end
      checks++; if (n !== 12) begin failures++; $display("FAIL clip_cycles case=%0d got=%0d want=12", k, n); end
      while (exp_q.size() > 0 && act_q.size() > 0) begin
        wr_t e, a;
        e = exp_q.pop_front(); a = act_q.pop_front();
        checks++; if (a !== e) begin failures++; $display("FAIL clip_write case=%0d got=%0d:%h want=%0d:%h", k, a.addr, a.data, e.addr, e.data); end
      end
    end
  endtask

  task automatic test_render();
    int n, nclr, bad_clr, bad_rdy;
    // End of field while idle must be ignored
    end_of_field = 1'b1; @(posedge clk); #1; end_of_field = 1'b0;
    checks++; if (front_sel !== 1'b0 || frame_cnt !== 16'd0) begin failures++; $display("FAIL render_idle_eof got=%b/%0d want=0/0", front_sel, frame_cnt); end
    cmd_data = {MAGIC_DO_RENDER, 40'd0}; cmd_valid = 1'b1;
    @(posedge clk); #1;
    // Keep a command pending: it must not be popped while waiting for the field
    cmd_data = {8'h7E, 40'd0};
    bad_rdy = 0;
    for (int i = 0; i < 49; i++) begin
      @(posedge clk); #1;
      if (cmd_ready) bad_rdy++;
    end
    cmd_valid = 1'b0;
    checks++; if (bad_rdy !== 0) begin failures++; $display("FAIL render_ready_busy got=%0d want=0", bad_rdy); end
    checks++; if (busy !== 1'b1 || front_sel !== 1'b0) begin failures++; $display("FAIL render_waiting got=%b/%b want=1/0", busy, front_sel); end
    end_of_field = 1'b1; @(posedge clk); #1; end_of_field = 1'b0;
    checks++; if (front_sel !== 1'b1) begin failures++; $display("FAIL render_front_sel got=%b want=1", front_sel); end
    checks++; if (frame_cnt !== 16'd1) begin failures++; $display("FAIL render_frame_cnt got=%0d want=1", frame_cnt); end
    nclr = 0; bad_clr = 0; n = 0;
    do begin
      @(posedge clk); #1;
      n++;
      if (fb_we) begin
        if (fb_addr !== FB_AW'(nclr) || fb_din !== 24'd0) bad_clr++;
        nclr++;
      end
    end while ((busy || fb_we) && n < int'(SW * SH) + 20);
    checks++; if (nclr !== int'(SW * SH)) begin failures++; $display("FAIL render_clear_count got=%0d want=%0d", nclr, SW * SH); end
    checks++; if (bad_clr !== 0) begin failures++; $display("FAIL render_clear_data got=%0d want=0", bad_clr); end
    checks++; if (busy !== 1'b0 || front_sel !== 1'b1) begin failures++; $display("FAIL render_done got=%b/%b want=0/1", busy, front_sel); end
    act_q.delete();
  endtask

  task automatic test_reset_mid_draw();
    int n, fw;
    exp_q.delete(); act_q.delete();
    model_sprite(16, 16, 16, 100, 10, 8'h00);
    cmd_data = {MAGIC_SPR_BIG, 16'd100, 16'd10, 8'h00}; cmd_valid = 1'b1;
    @(posedge clk); #1; cmd_valid = 1'b0;
    n = 0;
    while (act_q.size() < 30 && n < 100) begin @(posedge clk); #1; n++; end
    reset = 1'b1;
    @(posedge clk); #1;
    checks++; if (fb_we !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL midreset_idle got=%b/%b want=0/0", fb_we, busy); end
    checks++; if (front_sel !== 1'b0 || frame_cnt !== 16'd0) begin failures++; $display("FAIL midreset_swap_state got=%b/%0d want=0/0", front_sel, frame_cnt); end
    reset = 1'b0;
    checks++; if (act_q.size() < 30) begin failures++; $display("FAIL midreset_partial got=%0d want>=30", act_q.size()); end
    for (int i = 0; i < 30 && i < act_q.size(); i++) begin
      checks++; if (act_q[i] !== exp_q[i]) begin failures++; $display("FAIL midreset_write idx=%0d got=%0d:%h want=%0d:%h", i, act_q[i].addr, act_q[i].data, exp_q[i].addr, exp_q[i].data); end
    end
    @(posedge clk); #1;
    // Unknown magic and zero-width sprite: popped, no writes, straight back to idle
    act_q.delete();
    send_cmd(8'h7E, 50, 20, 8'h00, 50, n, fw);
    checks++; if (n !== 2 || act_q.size() !== 0) begin failures++; $display("FAIL unknown_magic got=%0d/%0d want=2/0", n, act_q.size()); end
    send_cmd(MAGIC_SPR_EMPTY, 50, 20, 8'h00, 50, n, fw);
    checks++; if (n !== 2 || act_q.size() !== 0) begin failures++; $display("FAIL empty_sprite got=%0d/%0d want=2/0", n, act_q.size()); end
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) rom[i] = {8'(i), 8'hA5, 8'(i * 3)};
    rom[2] = KEY;
    cmd_valid = 1'b0; cmd_data = '0; end_of_field = 1'b0; reset = 1'b1;
    test_reset();
    test_basic();
    test_hflip();
    test_transp();
    test_clip();
    test_render();
    test_reset_mid_draw();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog timeout got=running want=finished");
    $fatal(1, "watchdog");
  end

endmodule
